// File: rtl/kernel_pkg.sv
`default_nettype none
// ============================================================================
// kernel_pkg : command opcodes and sequencer state encoding for the kernel memory
// Revision   : 1.0 - initial release
// ============================================================================
package kernel_pkg;

  localparam logic KMC_OP_LOAD = 1'b0;
  localparam logic KMC_OP_RUN  = 1'b1;

  localparam int KMC_ST_W = 3;

  localparam logic [KMC_ST_W-1:0] KMC_ST_IDLE   = 3'd0;
  localparam logic [KMC_ST_W-1:0] KMC_ST_WCFG   = 3'd1;
  localparam logic [KMC_ST_W-1:0] KMC_ST_RCFG   = 3'd2;
  localparam logic [KMC_ST_W-1:0] KMC_ST_PRIME0 = 3'd3;
  localparam logic [KMC_ST_W-1:0] KMC_ST_PRIME1 = 3'd4;
  localparam logic [KMC_ST_W-1:0] KMC_ST_STREAM = 3'd5;

endpackage
`default_nettype wire

// File: rtl/kernel_mem_ctrl.sv
`default_nettype none
// ============================================================================
// kernel_mem_ctrl : LOAD/RUN sequencer and read-stream gate for kernel/bias memory
// Revision        : 1.0 - initial release
// ============================================================================
module kernel_mem_ctrl
  import kernel_pkg::*;
#(
  parameter int MEM_AWIDTH = 16,
  parameter int RPT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_op_i,
  input  logic [MEM_AWIDTH-1:0] cmd_arg0_i,
  input  logic [MEM_AWIDTH-1:0] cmd_arg1_i,
  input  logic [RPT_WIDTH-1:0]  cmd_rpt_i,
  input  logic                  cmd_val_i,
  output logic                  cmd_rdy_o,
  output logic [MEM_AWIDTH-1:0] mem_wr_cfg_end_o,
  output logic                  mem_wr_cfg_set_o,
  output logic [MEM_AWIDTH-1:0] mem_rd_cfg_start_o,
  output logic [MEM_AWIDTH-1:0] mem_rd_cfg_end_o,
  output logic                  mem_rd_cfg_set_o,
  output logic                  mem_rd_data_rdy_o,
  output logic                  ker_val_o,
  input  logic                  ker_rdy_i,
  output logic                  ker_last_o,
  output logic                  run_done_o,
  output logic                  cmd_err_o
);

  localparam logic [MEM_AWIDTH-1:0] c_aw_one  = MEM_AWIDTH'(1);
  localparam logic [RPT_WIDTH-1:0]  c_rpt_one = RPT_WIDTH'(1);

  logic [KMC_ST_W-1:0]   state_q, state_d;
  logic [MEM_AWIDTH-1:0] wr_end_q, wr_end_d;
  logic [MEM_AWIDTH-1:0] rd_start_q, rd_start_d;
  logic [MEM_AWIDTH-1:0] rd_end_q, rd_end_d;
  logic [MEM_AWIDTH-1:0] pass_len_q, pass_len_d;
  logic [MEM_AWIDTH-1:0] wcnt_q, wcnt_d;
  logic [RPT_WIDTH-1:0]  rpt_q, rpt_d;
  logic [RPT_WIDTH-1:0]  pass_q, pass_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  run_done_q, run_done_d;

  logic w_accept, w_pop, w_final;

  assign w_accept = cmd_val_i & cmd_rdy_o;
  assign w_pop    = ker_val_o & ker_rdy_i;
  // A zero-length window makes every word the end of a pass.
  assign ker_last_o = ker_val_o & ((pass_len_q == '0) | (wcnt_q == pass_len_q - c_aw_one));
  assign w_final  = w_pop & ker_last_o & (pass_q == rpt_q - c_rpt_one);

  assign mem_rd_data_rdy_o  = w_pop;
  assign mem_wr_cfg_end_o   = wr_end_q;
  assign mem_rd_cfg_start_o = rd_start_q;
  assign mem_rd_cfg_end_o   = rd_end_q;
  assign run_done_o         = run_done_q;
  assign cmd_err_o          = cmd_err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= KMC_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      KMC_ST_IDLE: begin
        if (w_accept) begin
          if (cmd_op_i == KMC_OP_RUN)  state_d = KMC_ST_RCFG;
          else if (cmd_arg0_i != '0)   state_d = KMC_ST_WCFG;
        end
      end
      KMC_ST_WCFG:   state_d = KMC_ST_IDLE;
      KMC_ST_RCFG:   state_d = KMC_ST_PRIME0;
      KMC_ST_PRIME0: state_d = KMC_ST_PRIME1;
      KMC_ST_PRIME1: state_d = KMC_ST_STREAM;
      KMC_ST_STREAM: if (w_final) state_d = KMC_ST_IDLE;
      default:       state_d = KMC_ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy_o        = 1'b0;
    mem_wr_cfg_set_o = 1'b0;
    mem_rd_cfg_set_o = 1'b0;
    ker_val_o        = 1'b0;
    case (state_q)
      KMC_ST_IDLE:   cmd_rdy_o        = 1'b1;
      KMC_ST_WCFG:   mem_wr_cfg_set_o = 1'b1;
      KMC_ST_RCFG:   mem_rd_cfg_set_o = 1'b1;
      KMC_ST_STREAM: ker_val_o        = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wr_end_d   = wr_end_q;
    rd_start_d = rd_start_q;
    rd_end_d   = rd_end_q;
    pass_len_d = pass_len_q;
    rpt_d      = rpt_q;
    wcnt_d     = wcnt_q;
    pass_d     = pass_q;
    cmd_err_d  = 1'b0;
    run_done_d = w_final;
    if (w_accept && cmd_op_i == KMC_OP_LOAD) begin
      wr_end_d  = wr_end_q + cmd_arg0_i;
      cmd_err_d = (cmd_arg0_i == '0);
    end
    if (w_accept && cmd_op_i == KMC_OP_RUN) begin
      rd_start_d = cmd_arg0_i;
      rd_end_d   = cmd_arg1_i;
      pass_len_d = cmd_arg1_i - cmd_arg0_i;
      rpt_d      = (cmd_rpt_i == '0) ? c_rpt_one : cmd_rpt_i;
      wcnt_d     = '0;
      pass_d     = '0;
    end
    if (w_pop) begin
      if (ker_last_o) begin
        wcnt_d = '0;
        pass_d = pass_q + c_rpt_one;
      end else begin
        wcnt_d = wcnt_q + c_aw_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_end_q   <= '0;
      rd_start_q <= '0;
      rd_end_q   <= '0;
      pass_len_q <= '0;
      rpt_q      <= c_rpt_one;
      wcnt_q     <= '0;
      pass_q     <= '0;
      cmd_err_q  <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      wr_end_q   <= wr_end_d;
      rd_start_q <= rd_start_d;
      rd_end_q   <= rd_end_d;
      pass_len_q <= pass_len_d;
      rpt_q      <= rpt_d;
      wcnt_q     <= wcnt_d;
      pass_q     <= pass_d;
      cmd_err_q  <= cmd_err_d;
      run_done_q <= run_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kernel_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_kernel_mem_ctrl : directed bench with a queue-based reference model
// Revision           : 1.0 - initial release
// ============================================================================
module tb_kernel_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_op = 1'b0;
  logic [15:0] cmd_arg0 = '0, cmd_arg1 = '0, cmd_rpt = '0;
  logic        cmd_val = 1'b0;
  logic        ker_rdy = 1'b1;
  logic        cmd_rdy_o, mem_wr_cfg_set_o, mem_rd_cfg_set_o, mem_rd_data_rdy_o;
  logic        ker_val_o, ker_last_o, run_done_o, cmd_err_o;
  logic [15:0] mem_wr_cfg_end_o, mem_rd_cfg_start_o, mem_rd_cfg_end_o;

  int checks = 0;
  int errors = 0;

  kernel_mem_ctrl #(.MEM_AWIDTH(16), .RPT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_op_i(cmd_op), .cmd_arg0_i(cmd_arg0), .cmd_arg1_i(cmd_arg1),
    .cmd_rpt_i(cmd_rpt), .cmd_val_i(cmd_val), .cmd_rdy_o(cmd_rdy_o),
    .mem_wr_cfg_end_o(mem_wr_cfg_end_o), .mem_wr_cfg_set_o(mem_wr_cfg_set_o),
    .mem_rd_cfg_start_o(mem_rd_cfg_start_o), .mem_rd_cfg_end_o(mem_rd_cfg_end_o),
    .mem_rd_cfg_set_o(mem_rd_cfg_set_o), .mem_rd_data_rdy_o(mem_rd_data_rdy_o),
    .ker_val_o(ker_val_o), .ker_rdy_i(ker_rdy), .ker_last_o(ker_last_o),
    .run_done_o(run_done_o), .cmd_err_o(cmd_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pulses, dead-cycle countdown, and a queue holding
  // the expected last-flag of every word still to be popped in the current RUN.
  logic [15:0] m_wr_end = '0, m_rs = '0, m_re = '0;
  bit          m_wset = 0, m_err = 0, m_done = 0;
  int          m_dead = 0;
  bit          m_q[$];

  always @(negedge clk) begin
    bit e_rdy, e_val, e_last;
    e_rdy  = !m_wset && m_dead == 0 && m_q.size() == 0;
    e_val  = m_dead == 0 && m_q.size() > 0;
    e_last = e_val && m_q[0];
    chk("m_cmd_rdy", 32'(cmd_rdy_o), 32'(e_rdy));
    chk("m_wr_set", 32'(mem_wr_cfg_set_o), 32'(m_wset));
    chk("m_wr_end", 32'(mem_wr_cfg_end_o), 32'(m_wr_end));
    chk("m_rd_set", 32'(mem_rd_cfg_set_o), 32'(m_dead == 3));
    chk("m_rd_start", 32'(mem_rd_cfg_start_o), 32'(m_rs));
    chk("m_rd_end", 32'(mem_rd_cfg_end_o), 32'(m_re));
    chk("m_ker_val", 32'(ker_val_o), 32'(e_val));
    chk("m_ker_last", 32'(ker_last_o), 32'(e_last));
    chk("m_mem_pop", 32'(mem_rd_data_rdy_o), 32'(e_val && ker_rdy));
    chk("m_run_done", 32'(run_done_o), 32'(m_done));
    chk("m_cmd_err", 32'(cmd_err_o), 32'(m_err));
    if (rst) begin
      m_wr_end = '0; m_rs = '0; m_re = '0;
      m_wset = 0; m_err = 0; m_done = 0; m_dead = 0;
      m_q.delete();
    end else begin
      m_wset = 0; m_err = 0; m_done = 0;
      if (m_dead > 0) m_dead--;
      else if (e_val && ker_rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1;
      end
      if (e_rdy && cmd_val) begin
        if (cmd_op == 1'b0) begin
          if (cmd_arg0 == 0) m_err = 1;
          else begin m_wr_end = m_wr_end + cmd_arg0; m_wset = 1; end
        end else begin
          logic [15:0] len;
          int wpp, np;
          m_rs = cmd_arg0; m_re = cmd_arg1;
          len = cmd_arg1 - cmd_arg0;
          wpp = (len == 0) ? 1 : int'(len);
          np  = (cmd_rpt == 0) ? 1 : int'(cmd_rpt);
          for (int i = 0; i < wpp * np; i++) m_q.push_back((i % wpp) == wpp - 1);
          m_dead = 3;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic op, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] r);
    bit acc = 0;
    int n = 0;
    cmd_op = op; cmd_arg0 = a0; cmd_arg1 = a1; cmd_rpt = r; cmd_val = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (cmd_rdy_o) acc = 1;
      @(posedge clk); #1;
      n++;
    end
    cmd_val = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Cycle c=0 is the cycle right after a RUN is accepted.
  task automatic observe(input bit tog, input int abort_c, output int rset_c,
                         output int first_c, output int npops, output int done_c,
                         output logic [31:0] mask);
    rset_c = -1; first_c = -1; npops = 0; done_c = -1; mask = '0;
    ker_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_rd_cfg_set_o && rset_c < 0) rset_c = c;
      if (mem_rd_data_rdy_o) begin
        if (first_c < 0) first_c = c;
        if (ker_last_o) mask = mask | (32'd1 << npops);
        npops++;
      end
      if (run_done_o && done_c < 0) done_c = c;
      if (abort_c >= 0 && c == abort_c + 1) begin
        chk("abort_cmd_rdy", 32'(cmd_rdy_o), 32'd1);
        chk("abort_ker_val", 32'(ker_val_o), 32'd0);
      end
      @(posedge clk); #1;
      ker_rdy = tog ? ((c + 1) % 2 == 0) : 1'b1;
      rst = (c + 1 == abort_c);
      if (done_c >= 0 && c >= done_c + 1) break;
    end
    ker_rdy = 1'b1;
  endtask

  int rs, fp, np, dn;
  logic [31:0] mk;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_rdy", 32'(cmd_rdy_o), 32'd1);
    chk("reset_wr_end", 32'(mem_wr_cfg_end_o), 32'd0);
    @(posedge clk); #1;

    send(1'b0, 16'd8, 16'd0, 16'd0);
    @(negedge clk);
    chk("load8_set", 32'(mem_wr_cfg_set_o), 32'd1);
    chk("load8_end", 32'(mem_wr_cfg_end_o), 32'h8);
    chk("load8_busy", 32'(cmd_rdy_o), 32'd0);
    @(negedge clk);
    chk("load8_rdy_back", 32'(cmd_rdy_o), 32'd1);
    @(posedge clk); #1;

    send(1'b0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("load0_err", 32'(cmd_err_o), 32'd1);
    chk("load0_noset", 32'(mem_wr_cfg_set_o), 32'd0);
    chk("load0_end", 32'(mem_wr_cfg_end_o), 32'h8);
    @(posedge clk); #1;

    send(1'b1, 16'd0, 16'd4, 16'd2);
    observe(1'b0, -1, rs, fp, np, dn, mk);
    chk("run_rset_c", 32'(rs), 32'd0);
    chk("run_first_pop", 32'(fp), 32'd3);
    chk("run_npops", 32'(np), 32'd8);
    chk("run_lastmask", mk, 32'h88);
    chk("run_done_c", 32'(dn), 32'd11);
    chk("run_rd_end", 32'(mem_rd_cfg_end_o), 32'h4);

    send(1'b1, 16'd0, 16'd4, 16'd2);
    observe(1'b1, -1, rs, fp, np, dn, mk);
    chk("tog_npops", 32'(np), 32'd8);
    chk("tog_lastmask", mk, 32'h88);
    chk("tog_done_c", 32'(dn), 32'd19);

    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(1'b0, 16'hFFF0, 16'd0, 16'd0);
    send(1'b0, 16'h0020, 16'd0, 16'd0);
    @(negedge clk);
    chk("wrap_set", 32'(mem_wr_cfg_set_o), 32'd1);
    chk("wrap_end", 32'(mem_wr_cfg_end_o), 32'h0010);
    @(posedge clk); #1;

    send(1'b1, 16'd0, 16'd4, 16'd2);
    observe(1'b0, 5, rs, fp, np, dn, mk);
    chk("abort_npops", 32'(np), 32'd3);
    chk("abort_no_done", 32'(dn), 32'hFFFF_FFFF);

    send(1'b1, 16'd2, 16'd5, 16'd0);
    observe(1'b0, -1, rs, fp, np, dn, mk);
    chk("rpt0_npops", 32'(np), 32'd3);
    chk("rpt0_lastmask", mk, 32'h4);
    chk("rpt0_done_c", 32'(dn), 32'd6);
    chk("rpt0_rd_start", 32'(mem_rd_cfg_start_o), 32'h2);

    send(1'b1, 16'd7, 16'd7, 16'd3);
    observe(1'b0, -1, rs, fp, np, dn, mk);
    chk("len0_npops", 32'(np), 32'd3);
    chk("len0_lastmask", mk, 32'h7);
    chk("len0_done_c", 32'(dn), 32'd6);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
